// File: rtl/data_cache_pkg.sv
// Shared types, default geometry and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int unsigned DCACHE_DATA_W = 32;
  localparam int unsigned DCACHE_ADDR_W = 32;
  localparam int unsigned DCACHE_SETS   = 64;
  localparam int unsigned INDEX_W       = $clog2(DCACHE_SETS);
  localparam int unsigned TAG_W         = DCACHE_ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } dcache_state_t;

  function automatic logic [7:0] byte_select(input logic [31:0] word, input logic [1:0] off);
    return word[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Backing-memory request port: cache is master, data memory is slave.
interface data_cache_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic                  byte_op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (
    output req, we, byte_op, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, byte_op, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: one combinational read port, one byte-masked synchronous write port.
module data_cache_array
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DCACHE_DATA_W,
  parameter int unsigned SETS       = DCACHE_SETS,
  parameter int unsigned IndexW     = INDEX_W,
  parameter int unsigned TagW       = TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IndexW-1:0]       rd_idx_i,
  output logic                    rd_valid_o,
  output logic [TagW-1:0]         rd_tag_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    wr_en_i,
  input  logic                    wr_set_valid_i,
  input  logic [IndexW-1:0]       wr_idx_i,
  input  logic [TagW-1:0]         wr_tag_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;

  logic [SETS-1:0]       valid_q;
  logic [TagW-1:0]       tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Data and tag need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i && !rst) begin
      if (wr_set_valid_i) begin
        tag_q[wr_idx_i] <= wr_tag_i;
      end
      for (int b = 0; b < Bytes; b++) begin
        if (wr_be_i[b]) begin
          data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache for the M stage.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DCACHE_DATA_W,
  parameter int unsigned ADDR_WIDTH = DCACHE_ADDR_W,
  parameter int unsigned SETS       = DCACHE_SETS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic                  byte_op_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  data_cache_if.master          mem
);

  localparam int unsigned IndexW = $clog2(SETS);
  localparam int unsigned TagW   = ADDR_WIDTH - IndexW - 2;
  localparam int unsigned Bytes  = DATA_WIDTH / 8;

  dcache_state_t         state_q;
  logic                  mem_req_q, mem_we_q, mem_byte_op_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [IndexW-1:0]     cpu_idx;
  logic [TagW-1:0]       cpu_tag;
  logic                  arr_valid;
  logic [TagW-1:0]       arr_tag;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic                  hit;
  logic [7:0]            sel_byte;

  logic                  arr_we, arr_set_valid;
  logic [IndexW-1:0]     arr_idx;
  logic [TagW-1:0]       arr_wtag;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [Bytes-1:0]      arr_be;

  assign cpu_idx  = addr_i[2 +: IndexW];
  assign cpu_tag  = addr_i[ADDR_WIDTH-1 -: TagW];
  assign hit      = arr_valid && (arr_tag == cpu_tag);
  assign sel_byte = byte_select(arr_rdata[31:0], addr_i[1:0]);

  data_cache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .SETS       (SETS),
    .IndexW     (IndexW),
    .TagW       (TagW)
  ) u_array (
    .clk            (clk),
    .rst            (rst),
    .rd_idx_i       (cpu_idx),
    .rd_valid_o     (arr_valid),
    .rd_tag_o       (arr_tag),
    .rd_data_o      (arr_rdata),
    .wr_en_i        (arr_we),
    .wr_set_valid_i (arr_set_valid),
    .wr_idx_i       (arr_idx),
    .wr_tag_i       (arr_wtag),
    .wr_data_i      (arr_wdata),
    .wr_be_i        (arr_be)
  );

  always_comb begin
    arr_we        = 1'b0;
    arr_set_valid = 1'b0;
    arr_idx       = cpu_idx;
    arr_wtag      = cpu_tag;
    arr_wdata     = wdata_i;
    arr_be        = '0;
    stall_o       = 1'b0;
    rdata_o       = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (we_i) begin
            stall_o = 1'b1;
            // Store hit updates the resident word on the latching edge; misses never allocate.
            if (hit) begin
              arr_we = 1'b1;
              if (byte_op_i) begin
                arr_wdata = {Bytes{wdata_i[7:0]}};
                arr_be    = {{(Bytes-1){1'b0}}, 1'b1} << addr_i[1:0];
              end else begin
                arr_be = '1;
              end
            end
          end else if (re_i) begin
            if (hit) begin
              rdata_o = byte_op_i ? {{(DATA_WIDTH-8){1'b0}}, sel_byte} : arr_rdata;
            end else begin
              stall_o = 1'b1;
            end
          end
        end
        RD_MISS: begin
          stall_o = 1'b1;
          if (mem.ready) begin
            arr_we        = 1'b1;
            arr_set_valid = 1'b1;
            arr_idx       = mem_addr_q[2 +: IndexW];
            arr_wtag      = mem_addr_q[ADDR_WIDTH-1 -: TagW];
            arr_wdata     = mem.rdata;
            arr_be        = '1;
          end
        end
        WR_THRU: stall_o = !mem.ready;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_byte_op_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (we_i) begin
            state_q       <= WR_THRU;
            mem_req_q     <= 1'b1;
            mem_we_q      <= 1'b1;
            mem_byte_op_q <= byte_op_i;
            mem_addr_q    <= addr_i;
            mem_wdata_q   <= wdata_i;
          end else if (re_i && !hit) begin
            state_q       <= RD_MISS;
            mem_req_q     <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_byte_op_q <= 1'b0;
            mem_addr_q    <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
          end
        end
        RD_MISS, WR_THRU: begin
          if (mem.ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.req     = mem_req_q;
  assign mem.we      = mem_we_q;
  assign mem.byte_op = mem_byte_op_q;
  assign mem.addr    = mem_addr_q;
  assign mem.wdata   = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed table, reset-abort sequence, random ops vs a model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_re, cpu_we, cpu_bop;
  logic [31:0] rdata_o;
  logic        stall_o;

  data_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_if ();

  data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (cpu_addr),
    .wdata_i   (cpu_wdata),
    .re_i      (cpu_re),
    .we_i      (cpu_we),
    .byte_op_i (cpu_bop),
    .rdata_o   (rdata_o),
    .stall_o   (stall_o),
    .mem       (mem_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat = 3;
  int n_rd = 0;
  int n_wr = 0;
  logic [31:0] last_rd_addr, last_wr_addr;
  logic        last_wr_bop;

  logic [31:0] bus_mem   [logic [31:0]];
  logic [7:0]  ref_bytes [logic [31:0]];
  logic [31:0] resident  [int];

  function automatic logic [31:0] init_word(input logic [31:0] waddr);
    if (waddr == 32'h100) return 32'hDEAD_BEEF;
    if (waddr == 32'h200) return 32'h1234_5678;
    return waddr ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] waddr);
    return bus_mem.exists(waddr) ? bus_mem[waddr] : init_word(waddr);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_bytes.exists(a)) return ref_bytes[a];
    w = init_word(a & ~32'h3);
    return w[8*a[1:0] +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Backing memory: answers each request after `lat` request cycles.
  initial begin
    logic [31:0] w, wa;
    int cnt;
    cnt = 0;
    mem_if.ready = 1'b0;
    mem_if.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_if.req) begin
        cnt++;
        if (cnt >= lat) begin
          mem_if.ready = 1'b1;
          wa = mem_if.addr & ~32'h3;
          if (mem_if.we) begin
            w = bus_rd(wa);
            if (mem_if.byte_op) w[8*mem_if.addr[1:0] +: 8] = mem_if.wdata[7:0];
            else w = mem_if.wdata;
            bus_mem[wa] = w;
            last_wr_addr = mem_if.addr;
            last_wr_bop  = mem_if.byte_op;
            n_wr++;
          end else begin
            mem_if.rdata = bus_rd(wa);
            last_rd_addr = mem_if.addr;
            n_rd++;
          end
        end else begin
          mem_if.ready = 1'b0;
        end
      end else begin
        cnt = 0;
        mem_if.ready = 1'b0;
      end
    end
  end

  // Reference: memory is byte-addressed; the cache is a set of resident word addresses, one per index.
  task automatic model_op(input logic re, input logic we, input logic bop, input logic [31:0] a,
                          input logic [31:0] wd, output int es, output logic [31:0] erd,
                          output int enr, output int enw);
    logic [31:0] waddr;
    int idx;
    waddr = a & ~32'h3;
    idx = int'((a / 4) % 64);
    es = 0; erd = '0; enr = 0; enw = 0;
    if (we) begin
      es = lat;
      enw = 1;
      if (bop) ref_bytes[a] = wd[7:0];
      else for (int k = 0; k < 4; k++) ref_bytes[waddr + k] = wd[8*k +: 8];
    end else if (re) begin
      if (!(resident.exists(idx) && resident[idx] == waddr)) begin
        es = lat + 1;
        enr = 1;
        resident[idx] = waddr;
      end
      if (bop) erd = {24'b0, ref_byte(a)};
      else erd = {ref_byte(waddr + 3), ref_byte(waddr + 2), ref_byte(waddr + 1), ref_byte(waddr)};
    end
  endtask

  task automatic access(input logic re, input logic we, input logic bop, input logic [31:0] a,
                        input logic [31:0] wd, output int sc, output logic [31:0] rd);
    bit done;
    cpu_re = re; cpu_we = we; cpu_bop = bop; cpu_addr = a; cpu_wdata = wd;
    sc = 0; rd = '0; done = 0;
    while (!done && sc < 60) begin
      @(negedge clk);
      if (!stall_o) begin
        rd = rdata_o;
        done = 1;
      end else begin
        sc++;
      end
    end
    if (!done) check("stall_timeout", 32'(sc), 32'(lat + 1));
    @(posedge clk);
    #1;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_bop = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic re, input logic we, input logic bop,
                        input logic [31:0] a, input logic [31:0] wd);
    int es, enr, enw, sc, rd0, wr0;
    logic [31:0] erd, rd;
    rd0 = n_rd; wr0 = n_wr;
    model_op(re, we, bop, a, wd, es, erd, enr, enw);
    access(re, we, bop, a, wd, sc, rd);
    check({tag, "_stall"}, 32'(sc), 32'(es));
    if (re && !we) check({tag, "_rdata"}, rd, erd);
    check({tag, "_nrd"}, 32'(n_rd - rd0), 32'(enr));
    check({tag, "_nwr"}, 32'(n_wr - wr0), 32'(enw));
    if (enr == 1) check({tag, "_rdaddr"}, last_rd_addr, a & ~32'h3);
    if (enw == 1) check({tag, "_wraddr"}, last_wr_addr, a);
  endtask

  typedef struct {
    logic        re, we, bop;
    logic [31:0] addr, wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    int          exp_nrd, exp_nwr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int es, enr, enw, sc, rd0, wr0;
    logic [31:0] erd, rd;
    string nm;

    vecs[0]  = '{1, 0, 0, 32'h100, 32'h0,         4, 32'hDEAD_BEEF, 1, 0};
    vecs[1]  = '{1, 0, 0, 32'h100, 32'h0,         0, 32'hDEAD_BEEF, 0, 0};
    vecs[2]  = '{0, 1, 1, 32'h101, 32'h0000_00AA, 3, 32'h0,         0, 1};
    vecs[3]  = '{1, 0, 0, 32'h100, 32'h0,         0, 32'hDEAD_AAEF, 0, 0};
    vecs[4]  = '{1, 0, 1, 32'h101, 32'h0,         0, 32'h0000_00AA, 0, 0};
    vecs[5]  = '{1, 0, 0, 32'h200, 32'h0,         4, 32'h1234_5678, 1, 0};
    vecs[6]  = '{1, 0, 0, 32'h100, 32'h0,         4, 32'hDEAD_AAEF, 1, 0};
    vecs[7]  = '{0, 1, 0, 32'h300, 32'hCAFE_F00D, 3, 32'h0,         0, 1};
    vecs[8]  = '{1, 0, 0, 32'h300, 32'h0,         4, 32'hCAFE_F00D, 1, 0};
    vecs[9]  = '{1, 1, 0, 32'h104, 32'h1122_3344, 3, 32'h0,         0, 1};
    vecs[10] = '{1, 0, 0, 32'h104, 32'h0,         4, 32'h1122_3344, 1, 0};
    vecs[11] = '{0, 0, 0, 32'h104, 32'h0,         0, 32'h0,         0, 0};
    vecs[12] = '{1, 0, 1, 32'h106, 32'h0,         0, 32'h0000_0022, 0, 0};

    rst = 1'b1;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_bop = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_req", {31'b0, mem_if.req}, 32'h0);
    check("reset_we", {31'b0, mem_if.we}, 32'h0);
    check("reset_byte_op", {31'b0, mem_if.byte_op}, 32'h0);
    check("reset_addr", mem_if.addr, 32'h0);
    check("reset_wdata", mem_if.wdata, 32'h0);
    @(posedge clk);
    #1;

    lat = 3;
    for (int i = 0; i < 13; i++) begin
      nm = $sformatf("vec%0d", i);
      rd0 = n_rd; wr0 = n_wr;
      model_op(vecs[i].re, vecs[i].we, vecs[i].bop, vecs[i].addr, vecs[i].wdata, es, erd, enr, enw);
      access(vecs[i].re, vecs[i].we, vecs[i].bop, vecs[i].addr, vecs[i].wdata, sc, rd);
      check({nm, "_stall"}, 32'(sc), 32'(vecs[i].exp_stall));
      if (vecs[i].re && !vecs[i].we) check({nm, "_rdata"}, rd, vecs[i].exp_rdata);
      check({nm, "_nrd"}, 32'(n_rd - rd0), 32'(vecs[i].exp_nrd));
      check({nm, "_nwr"}, 32'(n_wr - wr0), 32'(vecs[i].exp_nwr));
      if (vecs[i].exp_nrd == 1) check({nm, "_rdaddr"}, last_rd_addr, vecs[i].addr & ~32'h3);
      if (vecs[i].exp_nwr == 1) begin
        check({nm, "_wraddr"}, last_wr_addr, vecs[i].addr);
        check({nm, "_wrbop"}, {31'b0, last_wr_bop}, {31'b0, vecs[i].bop});
      end
    end

    // Reset while a refill is outstanding.
    lat = 2;
    run_op("rst_pre_miss", 1, 0, 0, 32'h100, 32'h0);
    run_op("rst_pre_hit", 1, 0, 0, 32'h100, 32'h0);
    lat = 10;
    rd0 = n_rd;
    cpu_re = 1'b1; cpu_addr = 32'h200; cpu_bop = 1'b0;
    @(negedge clk);
    check("abort_stall_idle", {31'b0, stall_o}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_req_busy", {31'b0, mem_if.req}, 32'h1);
    check("abort_addr_busy", mem_if.addr, 32'h200);
    @(posedge clk);
    #1;
    rst = 1'b1; cpu_re = 1'b0;
    @(negedge clk);
    check("abort_stall_in_rst", {31'b0, stall_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resident.delete();
    @(negedge clk);
    check("abort_req_after", {31'b0, mem_if.req}, 32'h0);
    check("abort_stall_after", {31'b0, stall_o}, 32'h0);
    check("abort_no_read", 32'(n_rd - rd0), 32'h0);
    @(posedge clk);
    #1;
    lat = 2;
    run_op("post_rst_miss", 1, 0, 0, 32'h100, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int kind;
      lat = $urandom_range(1, 4);
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      nm = $sformatf("rnd%0d", i);
      if (kind == 0) run_op(nm, 0, 0, 0, a, $urandom);
      else if (kind <= 5) run_op(nm, 1, 0, 1'($urandom_range(0, 1)), a, $urandom);
      else if (kind <= 8) run_op(nm, 0, 1, 1'($urandom_range(0, 1)), a, $urandom);
      else run_op(nm, 1, 1, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
